zone_grid_selector: RTL
=======================

// Module: zone_grid_selector
// PURPOSE
//   Parametrised screen-zone classifier and cursor selector for the VGA application layer.
//   Maps the current pixel coordinate onto a COLS x ROWS grid of the active area in a
//   2-stage pipeline, and runs a small FSM that moves and locks a cursor zone from buttons.
//   Sits between the VGA timing counters and the colour generator; drives zone highlighting.
// PARAMETERS
//   H_ACTIVE  640  active pixels per line; horizontal >= H_ACTIVE is outside the grid
//   V_ACTIVE  480  active lines per frame; vertical >= V_ACTIVE is outside the grid
//   COLS      2    grid columns, 1..16
//   ROWS      2    grid rows, 1..16
//   ZW        $clog2(COLS*ROWS) (min 1)  zone index width; derived, not overridden
// PORTS
//   clk             in   1   system/pixel clock, rising edge
//   reset           in   1   asynchronous, active-high; clears all state
//   horizontal      in   10  current pixel column from timing generator
//   vertical        in   10  current pixel line from timing generator
//   btn_next        in   1   level, synchronised; a rising edge advances the cursor
//   btn_prev        in   1   level, synchronised; a rising edge moves the cursor back
//   btn_confirm     in   1   level, synchronised; a rising edge locks or unlocks
//   pixel_zone      out  ZW  zone of the pixel sampled 2 cycles earlier
//   pixel_valid     out  1   that pixel lay inside the active area
//   pixel_highlight out  1   pixel_valid & (pixel_zone == cursor_zone)
//   cursor_zone     out  ZW  current cursor zone
//   locked          out  1   FSM is in LOCKED
//   selected_zone   out  ZW  zone captured at the last lock
//   confirm_pulse   out  1   one-cycle strobe on every IDLE->LOCKED transition
// BEHAVIOUR
//   Reset (async): every output 0; FSM = IDLE; pipeline registers 0.
//     Button edge-history registers reset to 1, so a button held through reset gives no event.
//   Zone pipeline (no division, constant compares only):
//     Column boundary i = floor(i*H_ACTIVE/COLS); row boundary j = floor(j*V_ACTIVE/ROWS).
//     The last column/row absorbs any remainder.
//     S1 registers col = largest i with horizontal >= bound_i; row likewise; in = h<H_ACTIVE && v<V_ACTIVE.
//     S2 registers pixel_zone = row*COLS + col (row-major); pixel_valid = in; if !in, pixel_zone = 0.
//     pixel_highlight is computed at S2 against the cursor_zone value at that clock edge.
//     Latency: exactly 2 clk from coordinate to outputs; throughput 1 pixel/clk.
//   Button events: ev_x = btn_x & ~btn_x_q (1-cycle rising-edge detect).
//   FSM IDLE:
//     ev_confirm -> LOCKED; selected_zone <= cursor_zone; confirm_pulse = 1 for 1 cycle.
//     Otherwise ev_next alone -> cursor+1, wrapping N-1 -> 0 (N = COLS*ROWS).
//     Otherwise ev_prev alone -> cursor-1, wrapping 0 -> N-1.
//     ev_next & ev_prev in the same cycle -> no move.
//     ev_confirm has priority: coincident next/prev are dropped.
//   FSM LOCKED:
//     next/prev ignored, cursor frozen.
//     ev_confirm -> IDLE; selected_zone keeps its value; no pulse.
//   locked = (state == LOCKED); cursor_zone < N always; N=1 -> cursor stays 0.
//   Reset mid-operation: immediate return to IDLE, cursor 0, pipeline flushed to invalid.
// TESTING (defaults 640x480, 2x2)
//   (600,100) then (600,400), (100,400), (100,100) -> pixel_zone 1,3,2,0 each 2 clk later, valid=1.
//   (600,600) and (700,100) -> pixel_valid=0, pixel_zone=0; (320,240) -> zone 3; (319,239) -> zone 0.
//   4 next edges from reset -> cursor 1,2,3,0; 1 prev edge at 0 -> 3; next+prev together -> unchanged.
//   Cursor=2, confirm edge -> locked=1, selected_zone=2, confirm_pulse high exactly 1 clk.
//     Then next/prev ignored; second confirm -> locked=0, no pulse.
//   btn_next held high across reset release -> no cursor move; held 100 clk -> exactly 1 move.
//   Assert reset while LOCKED with a pipeline full of valid pixels -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/zone_grid_selector.sv
// Purpose: classify each pixel into a COLS x ROWS screen zone and run a button-driven cursor/lock FSM.
// Latency: pixel_zone/pixel_valid/pixel_highlight appear exactly 2 clk after the coordinate; cursor/lock update 1 clk after a button edge.
// Backpressure: none; accepts one pixel every clock and never stalls.
module zone_grid_selector #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COLS     = 2,
  parameter int ROWS     = 2,
  localparam int N       = COLS * ROWS,
  localparam int ZW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    horizontal,
  input  logic [9:0]    vertical,
  input  logic          btn_next,
  input  logic          btn_prev,
  input  logic          btn_confirm,
  output logic [ZW-1:0] pixel_zone,
  output logic          pixel_valid,
  output logic          pixel_highlight,
  output logic [ZW-1:0] cursor_zone,
  output logic          locked,
  output logic [ZW-1:0] selected_zone,
  output logic          confirm_pulse
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  // Boundaries are elaboration-time constants, so the compares below are against literals.
  function automatic logic [31:0] col_bound(input int i);
    return 32'(i * H_ACTIVE / COLS);
  endfunction

  function automatic logic [31:0] row_bound(input int j);
    return 32'(j * V_ACTIVE / ROWS);
  endfunction

  logic [31:0]   h_ext, v_ext;
  logic [CW-1:0] col_d, col_q;
  logic [RW-1:0] row_d, row_q;
  logic          in_d, in_q;
  logic [ZW-1:0] zone_d, zone_q;
  logic          hl_d, hl_q;
  logic          valid_q;

  logic          btn_next_q, btn_prev_q, btn_confirm_q;
  logic          ev_next, ev_prev, ev_confirm;
  state_t        state_d, state_q;
  logic [ZW-1:0] cursor_d, cursor_q;
  logic [ZW-1:0] selected_d, selected_q;
  logic          pulse_d, pulse_q;

  assign h_ext = {22'd0, horizontal};
  assign v_ext = {22'd0, vertical};

  // Stage 1 decode: the highest boundary not exceeding the coordinate gives the column/row;
  // the last column/row naturally absorbs any remainder.
  always_comb begin
    col_d = '0;
    row_d = '0;
    for (int i = 1; i < COLS; i++) begin
      if (h_ext >= col_bound(i)) col_d = CW'(i);
    end
    for (int j = 1; j < ROWS; j++) begin
      if (v_ext >= row_bound(j)) row_d = RW'(j);
    end
    in_d = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
  end

  // Stage 2 decode: row-major zone index, forced to 0 outside the active area;
  // highlight uses the cursor as it stands at this same edge.
  always_comb begin
    zone_d = in_q ? (ZW'(row_q) * ZW'(COLS) + ZW'(col_q)) : '0;
    hl_d   = in_q && (zone_d == cursor_q);
  end

  // Two-stage pixel pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      in_q    <= 1'b0;
      zone_q  <= '0;
      valid_q <= 1'b0;
      hl_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      in_q    <= in_d;
      zone_q  <= zone_d;
      valid_q <= in_q;
      hl_q    <= hl_d;
    end
  end

  // Button history resets high so a button already held at reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_next_q    <= 1'b1;
      btn_prev_q    <= 1'b1;
      btn_confirm_q <= 1'b1;
    end else begin
      btn_next_q    <= btn_next;
      btn_prev_q    <= btn_prev;
      btn_confirm_q <= btn_confirm;
    end
  end

  assign ev_next    = btn_next    & ~btn_next_q;
  assign ev_prev    = btn_prev    & ~btn_prev_q;
  assign ev_confirm = btn_confirm & ~btn_confirm_q;

  // Cursor/lock state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cursor_q   <= '0;
      selected_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      selected_q <= selected_d;
      pulse_q    <= pulse_d;
    end
  end

  // Next-state logic: confirm wins over movement; simultaneous next+prev cancel out.
  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    selected_d = selected_q;
    pulse_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_confirm) begin
          state_d    = LOCKED;
          selected_d = cursor_q;
          pulse_d    = 1'b1;
        end else if (ev_next && !ev_prev) begin
          cursor_d = (cursor_q == ZW'(N - 1)) ? '0 : cursor_q + ZW'(1);
        end else if (ev_prev && !ev_next) begin
          cursor_d = (cursor_q == '0) ? ZW'(N - 1) : cursor_q - ZW'(1);
        end
      end
      LOCKED: begin
        if (ev_confirm) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pixel_zone      = zone_q;
  assign pixel_valid     = valid_q;
  assign pixel_highlight = hl_q;
  assign cursor_zone     = cursor_q;
  assign locked          = (state_q == LOCKED);
  assign selected_zone   = selected_q;
  assign confirm_pulse   = pulse_q;

endmodule
